rgb_mixer_n: RTL and testbench
==============================

Name: rgb_mixer_n

Overview:
Parametrised N-channel encoder-to-PWM mixer. It generalises the fixed three-channel RGB mixer to configurable channel count, level width, debounce length, step size and overflow mode. It adds a host preset/load port, glitch-free PWM level updates and a readback bus. It sits between the board's rotary-encoder pins and the LED drivers.

Parameters:
NUM_CH, 3, number of independent encoder/PWM channels (1..8)
WIDTH, 8, level and PWM counter width in bits (4..12)
DB_CYCLES, 4, consecutive stable synchronised samples required before a debounced input changes (1..255)
STEP, 1, level change per detent (1..2^WIDTH-1)
SATURATE, 1, 1 = clamp at 0 and 2^WIDTH-1; 0 = wrap modulo 2^WIDTH

Ports:
clk  input  1  single system clock
reset  input  1  synchronous, active-high reset
enc_a  input  NUM_CH  raw encoder A per channel (async, bouncy)
enc_b  input  NUM_CH  raw encoder B per channel (async, bouncy)
load_valid  input  1  host preset strobe, one cycle
load_ch  input  3  target channel of preset
load_value  input  WIDTH  preset level
pwm_out  output  NUM_CH  PWM output per channel
level_out  output  NUM_CH*WIDTH  current level per channel; channel i at bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset: one clock, synchronous, active-high. All synchroniser flops, debounce counters, debounced values, encoder history, levels, active levels and the PWM counter go to 0. Resulting outputs: pwm_out=0, level_out=0. A reset mid-rotation or mid-load discards that event.
- Input sync: each enc_a/enc_b passes through 2 flops.
- Debounce: per input, a counter runs while the synchronised value differs from the debounced value and clears on any agreement. When the count reaches DB_CYCLES the debounced value flips and the counter clears. A clean step input is reflected in the debounced value 2+DB_CYCLES edges after first sampling. Any glitch shorter than DB_CYCLES samples produces no change.
- Encoder: registered previous debounced a/b per channel. Events, evaluated on debounced values:
  - a rises while b=0, or a falls while b=1: +STEP
  - b rises while a=0, or b falls while a=1: -STEP
  - a and b changing in the same cycle: ignored
- The level register updates on the cycle after the debounced edge.
- Arithmetic: compute in WIDTH+1 bits.
  - SATURATE=1: result above 2^WIDTH-1 gives 2^WIDTH-1; result below 0 gives 0.
  - SATURATE=0: keep the low WIDTH bits.
- Load: when load_valid=1 and load_ch<NUM_CH, level[load_ch] <= load_value on that edge. Load has priority over a same-cycle encoder event on that channel, and the event is dropped. load_ch>=NUM_CH: ignored.
- level_out: shows the level register directly, one cycle after the change.
- PWM:
  - One shared free-running WIDTH-bit counter, incrementing each clk and wrapping 2^WIDTH-1 -> 0. Period is 2^WIDTH cycles.
  - Each channel holds active_level, copied from level only on the edge where the counter wraps to 0. Level changes therefore never truncate a period.
  - pwm_out[i] is registered, =1 when counter < active_level[i]. Level 0: constantly low. Level 2^WIDTH-1: high 2^WIDTH-1 of every 2^WIDTH cycles.

Decomposition:
- Package rgb_mixer_pkg holds:
  - the encoder event encoding (EV_NONE, EV_INC, EV_DEC)
  - the saturating/wrapping step function parameterised by WIDTH/STEP/SATURATE
  - the channel-index width constant
- One sub-module, mixer_channel, holds one channel's 2x sync+debounce, encoder, level register and active_level/compare. It takes the shared counter and wrap pulse from the top.
- The top level rgb_mixer_n holds the PWM counter, load decode and a generate loop over NUM_CH.

Test Plan:
1. Defaults. Reset, then 3 clean CW detents on ch0 (a rises with b=0, then a falls with b=1, ...) -> level_out ch0 = 3; ch1 and ch2 stay 0; pwm_out[0] high exactly 3 of 256 cycles starting from the first period after the change.
2. Saturation. SATURATE=1, load ch1 = 254, 3 CW detents -> level 255 and it stays there. Load 1, 3 CCW detents -> 0. SATURATE=0, level 255 + 1 CW -> 0.
3. Bounce rejection. DB_CYCLES=4: toggle enc_a for 3-cycle pulses 10 times -> no level change. A 6-cycle stable edge -> exactly one step, at 2+4 edges plus 1 after sampling.
4. Load priority and range.
   - load ch2=0x80 in the same cycle as a CW event on ch2 -> level 0x80.
   - load_ch=5 with NUM_CH=3 -> no register changes.
5. Glitch-free PWM. Ch0 level 200, change to 10 at counter=50 -> the current period still gives 200 high cycles, the next period 10. Level 0 -> pwm_out never high.
6. Reset mid-operation. Assert reset for 1 cycle while a debounce count is in progress and pwm_out=1 -> next cycle all outputs 0, and the pending edge produces no step.

Source files
------------

// File: rtl/rgb_mixer_pkg.sv
// rgb_mixer_pkg: shared types, widths and the level step function for the
// N-channel encoder-to-PWM mixer.
//   enc_ev_e    : per-channel encoder event (none / increment / decrement)
//   CH_IDX_W    : width of the host channel-select field
//   MAX_W       : widest supported level, sizes the step function datapath
//   DB_CNT_W    : debounce counter width (covers DB_CYCLES up to 255)
//   step_level(): apply one signed step with clamp or modulo behaviour
package rgb_mixer_pkg;

  localparam int unsigned CH_IDX_W = 3;
  localparam int unsigned MAX_W    = 12;
  localparam int unsigned DB_CNT_W = 8;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_INC  = 2'd1,
    EV_DEC  = 2'd2
  } enc_ev_e;

  // Step a level by +/-step in (width+1)-bit arithmetic. Levels narrower than
  // MAX_W arrive zero-extended; the result is masked back to 'width' bits, so
  // the wrap mode is modulo 2^width and the saturate mode clamps to 0/2^width-1.
  function automatic logic [MAX_W-1:0] step_level(
    input logic [MAX_W-1:0] level,
    input enc_ev_e          ev,
    input int unsigned      width,
    input logic [MAX_W-1:0] step,
    input logic             saturate
  );
    logic [MAX_W:0] full_max;
    logic [MAX_W:0] res;
    full_max = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < width) full_max[i] = 1'b1;
    end
    res = {1'b0, level};
    case (ev)
      EV_INC: begin
        res = {1'b0, level} + {1'b0, step};
        if (saturate && (res > full_max)) res = full_max;
      end
      EV_DEC: begin
        if (saturate && (step > level)) res = '0;
        else                            res = {1'b0, level} - {1'b0, step};
      end
      default: res = {1'b0, level};
    endcase
    return MAX_W'(res & full_max);
  endfunction

endpackage

// File: rtl/mixer_channel.sv
// mixer_channel: one encoder/PWM channel.
//   clk, reset  : system clock, synchronous active-high reset
//   enc_a/enc_b : raw asynchronous, bouncy encoder pins
//   load_en     : host preset for this channel (already decoded)
//   load_value  : preset level
//   pwm_cnt     : shared free-running PWM counter
//   wrap        : high on the cycle the shared counter is at its maximum
//   pwm         : registered PWM output
//   level       : current level register
module mixer_channel
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned STEP      = 1,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] pwm_cnt,
  input  logic             wrap,
  output logic             pwm,
  output logic [WIDTH-1:0] level
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

  // Index 0 is the A pin, index 1 the B pin throughout.
  logic [1:0]          raw;
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          db;
  logic [1:0]          prev;
  logic [DB_CNT_W-1:0] db_cnt [2];

  logic                a_chg;
  logic                b_chg;
  enc_ev_e             ev_c;
  logic [WIDTH-1:0]    next_level_c;
  logic [WIDTH-1:0]    active_level;

  assign raw = {enc_b, enc_a};

  // Two-flop synchroniser and per-pin debounce: a pin flips only after
  // DB_CYCLES consecutive disagreeing samples; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_cnt <= '{default: '0};
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_CNT_W'(1);
        end
      end
    end
  end

  // Previous debounced pins for edge detection.
  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= db;
  end

  // After a single-pin edge, the listed +STEP cases (a rise with b=0, a fall
  // with b=1) and -STEP cases (b rise with a=0, b fall with a=1) are exactly
  // those that leave the two pins unequal. Simultaneous edges are dropped.
  always_comb begin
    ev_c         = EV_NONE;
    a_chg        = db[0] ^ prev[0];
    b_chg        = db[1] ^ prev[1];
    if (a_chg && !b_chg && (db[0] != db[1])) ev_c = EV_INC;
    if (b_chg && !a_chg && (db[0] != db[1])) ev_c = EV_DEC;
    next_level_c = WIDTH'(step_level(MAX_W'(level), ev_c, WIDTH,
                                     MAX_W'(STEP), SATURATE));
  end

  // Level register; a host load wins over a same-cycle encoder event.
  always_ff @(posedge clk) begin
    if (reset)                  level <= '0;
    else if (load_en)           level <= load_value;
    else if (ev_c != EV_NONE)   level <= next_level_c;
  end

  // The compare level is only refreshed as the counter wraps, so a period in
  // flight is never shortened or stretched by a level change.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_level <= '0;
      pwm          <= 1'b0;
    end else begin
      if (wrap) active_level <= level;
      pwm <= (pwm_cnt < active_level);
    end
  end

endmodule

// File: rtl/rgb_mixer_n.sv
// rgb_mixer_n: N-channel rotary-encoder to PWM mixer with host preset port.
//   clk, reset : system clock, synchronous active-high reset
//   enc_a/enc_b: raw encoder pins, one bit per channel
//   load_valid : one-cycle host preset strobe
//   load_ch    : preset target channel (values >= NUM_CH are ignored)
//   load_value : preset level
//   pwm_out    : registered PWM output per channel
//   level_out  : level registers, channel i at [i*WIDTH +: WIDTH]
module rgb_mixer_n
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned STEP      = 1,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  input  logic                    load_valid,
  input  logic [CH_IDX_W-1:0]     load_ch,
  input  logic [WIDTH-1:0]        load_value,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH*WIDTH-1:0] level_out
);

  logic [WIDTH-1:0] pwm_cnt;
  logic             wrap_c;

  // Shared free-running PWM counter, period 2^WIDTH.
  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + WIDTH'(1);
  end

  assign wrap_c = (pwm_cnt == {WIDTH{1'b1}});

  // One channel per encoder; out-of-range load_ch matches no channel.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic load_en_c;
    assign load_en_c = load_valid && (load_ch == CH_IDX_W'(g));

    mixer_channel #(
      .WIDTH     (WIDTH),
      .DB_CYCLES (DB_CYCLES),
      .STEP      (STEP),
      .SATURATE  (SATURATE)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .enc_a      (enc_a[g]),
      .enc_b      (enc_b[g]),
      .load_en    (load_en_c),
      .load_value (load_value),
      .pwm_cnt    (pwm_cnt),
      .wrap       (wrap_c),
      .pwm        (pwm_out[g]),
      .level      (level_out[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_rgb_mixer_n.sv
// tb_rgb_mixer_n: directed bench for rgb_mixer_n. A saturating and a wrapping
// instance share all stimulus; expected levels come from a small model and
// travel through a scoreboard queue.
module tb_rgb_mixer_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  enc_a, enc_b;
  logic        load_valid;
  logic [2:0]  load_ch;
  logic [7:0]  load_value;
  logic [2:0]  pwm_s, pwm_w;
  logic [23:0] lvl_s, lvl_w;

  int checks = 0;
  int errors = 0;
  int lv_s[3];
  int lv_w[3];

  typedef struct {
    string       tag;
    logic [23:0] s;
    logic [23:0] w;
  } exp_t;
  exp_t sb[$];

  rgb_mixer_n #(.NUM_CH(3), .WIDTH(8), .DB_CYCLES(4), .STEP(1), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
    .pwm_out(pwm_s), .level_out(lvl_s));

  rgb_mixer_n #(.NUM_CH(3), .WIDTH(8), .DB_CYCLES(4), .STEP(1), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
    .pwm_out(pwm_w), .level_out(lvl_w));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pack_lv(input bit wrap);
    logic [23:0] r;
    for (int i = 0; i < 3; i++) r[i*8 +: 8] = 8'(wrap ? lv_w[i] : lv_s[i]);
    return r;
  endfunction

  task automatic model_step(input int ch, input int d);
    int v;
    v = lv_s[ch] + d;
    if (v > 255) v = 255;
    if (v < 0)   v = 0;
    lv_s[ch] = v;
    lv_w[ch] = (lv_w[ch] + d) & 255;
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag;
    e.s   = pack_lv(1'b0);
    e.w   = pack_lv(1'b1);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0d expected=%0d", 0, 1);
    end else begin
      e = sb.pop_front();
      assert ({lvl_s, lvl_w} === {e.s, e.w}) else begin
        errors++;
        $error("FAIL %s observed s=%h w=%h expected s=%h w=%h", e.tag, lvl_s, lvl_w, e.s, e.w);
      end
    end
  endtask

  // Drive one clean pin edge and predict its step from the event rules.
  task automatic move(input string tag, input int ch, input bit sel_b, input bit val);
    bit a, b, rise, fall;
    int d;
    d = 0;
    a = enc_a[ch];
    b = enc_b[ch];
    if (!sel_b) begin
      rise = val && !a;
      fall = !val && a;
      if ((rise && !b) || (fall && b)) d = 1;
      enc_a[ch] = val;
    end else begin
      rise = val && !b;
      fall = !val && b;
      if ((rise && !a) || (fall && a)) d = -1;
      enc_b[ch] = val;
    end
    if (d != 0) model_step(ch, d);
    push(tag);
    tick(10);
    pop_check();
  endtask

  task automatic cw(input string tag, input int ch);
    if (enc_a[ch] != enc_b[ch]) move({tag, "_n"}, ch, 1'b1, !enc_b[ch]);
    move(tag, ch, 1'b0, !enc_a[ch]);
  endtask

  task automatic ccw(input string tag, input int ch);
    if (enc_a[ch] != enc_b[ch]) move({tag, "_n"}, ch, 1'b0, !enc_a[ch]);
    move(tag, ch, 1'b1, !enc_b[ch]);
  endtask

  task automatic do_load(input string tag, input int ch, input int val);
    load_valid = 1'b1;
    load_ch    = 3'(ch);
    load_value = 8'(val);
    if (ch < 3) begin
      lv_s[ch] = val;
      lv_w[ch] = val;
    end
    push(tag);
    tick(1);
    load_valid = 1'b0;
    pop_check();
  endtask

  task automatic count_hi(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_s[ch]) hi++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  h;
    bit  seen;
    bit  prev;
    reset = 1'b1; enc_a = '0; enc_b = '0;
    load_valid = 1'b0; load_ch = '0; load_value = '0;
    for (int i = 0; i < 3; i++) begin lv_s[i] = 0; lv_w[i] = 0; end
    tick(2);
    chk("reset_lvl_s", 32'(lvl_s), 0);
    chk("reset_lvl_w", 32'(lvl_w), 0);
    chk("reset_pwm", 32'({pwm_s, pwm_w}), 0);
    reset = 1'b0;

    // Three clockwise detents on ch0, then duty over one full period.
    cw("t1_cw1", 0);
    cw("t1_cw2", 0);
    cw("t1_cw3", 0);
    tick(300);
    count_hi(0, 256, h);
    chk("t1_pwm0_hi", 32'(h), 3);
    count_hi(1, 256, h);
    chk("t1_pwm1_hi", 32'(h), 0);

    // Clamp vs wrap at both ends.
    do_load("t2_load254", 1, 254);
    cw("t2_up1", 1);
    cw("t2_up2", 1);
    cw("t2_up3", 1);
    do_load("t2_load1", 1, 1);
    ccw("t2_dn1", 1);
    ccw("t2_dn2", 1);
    ccw("t2_dn3", 1);

    // Short pulses rejected; a stable edge steps exactly 7 edges after drive.
    repeat (10) begin
      enc_a[2] = 1'b1; tick(3);
      enc_a[2] = 1'b0; tick(3);
    end
    push("t3_bounce");
    tick(10);
    pop_check();
    enc_a[2] = 1'b1;
    push("t3_early");
    tick(6);
    pop_check();
    model_step(2, 1);  // a rose with b=0
    push("t3_step");
    tick(1);
    pop_check();

    // Load lands on the same edge as an encoder event and wins.
    move("t4_pre", 2, 1'b1, 1'b1);
    enc_a[2] = 1'b0;   // a falls with b=1: would be +1
    tick(6);
    load_valid = 1'b1; load_ch = 3'd2; load_value = 8'h80;
    lv_s[2] = 8'h80; lv_w[2] = 8'h80;
    push("t4_prio");
    tick(1);
    load_valid = 1'b0;
    pop_check();
    push("t4_prio_hold");
    tick(10);
    pop_check();
    do_load("t4_range", 5, 8'h11);

    // Mid-period level change takes effect only from the next period.
    do_load("t5_200", 0, 200);
    tick(300);
    seen = 1'b0;
    prev = pwm_s[0];
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (!prev && pwm_s[0]) seen = 1'b1;
      prev = pwm_s[0];
    end
    chk("t5_found_rise", 32'(seen), 1);
    h = 1;
    lv_s[0] = 10; lv_w[0] = 10;
    push("t5_load10");
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      if (i == 50) begin load_valid = 1'b1; load_ch = 3'd0; load_value = 8'd10; end
      if (i == 51) load_valid = 1'b0;
      if (pwm_s[0]) h++;
    end
    chk("t5_cur_period", 32'(h), 200);
    count_hi(0, 256, h);
    chk("t5_next_period", 32'(h), 10);
    pop_check();
    do_load("t5_zero", 0, 0);
    tick(300);
    count_hi(0, 300, h);
    chk("t5_zero_pwm", 32'(h), 0);

    // Reset with a debounce count pending and pwm high.
    for (int ch = 0; ch < 3; ch++) begin
      if (enc_a[ch]) move("t6_park_a", ch, 1'b0, 1'b0);
      if (enc_b[ch]) move("t6_park_b", ch, 1'b1, 1'b0);
    end
    do_load("t6_ff", 0, 255);
    tick(300);
    enc_a[1] = 1'b1;   // rise with b=0, pending
    tick(3);
    for (int i = 0; i < 2 && !pwm_s[0]; i++) tick(1);
    chk("t6_pre_pwm", 32'(pwm_s[0]), 1);
    reset = 1'b1;
    enc_a[1] = 1'b0;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin lv_s[i] = 0; lv_w[i] = 0; end
    chk("t6_pwm_s", 32'(pwm_s), 0);
    chk("t6_pwm_w", 32'(pwm_w), 0);
    chk("t6_lvl_s", 32'(lvl_s), 0);
    chk("t6_lvl_w", 32'(lvl_w), 0);
    push("t6_no_step");
    tick(20);
    pop_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
